// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the vend dispense scheduler slice.
//   state_t   : scheduler FSM states
//   ITEM_A/B  : item select encoding carried on item_b
//   CHG_W_DEF : default width of a per-station change count
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISP,
        CHG_ON,
        CHG_OFF,
        DONE
    } state_t;

    localparam logic ITEM_A = 1'b0;
    localparam logic ITEM_B = 1'b1;

    localparam int CHG_W_DEF = 2;

endpackage

// File: rtl/vend_dispense_sched_if.sv
// vend_dispense_sched_if: station-side bus of the dispense scheduler.
//   req, item_b, chg_cnt0, chg_cnt1 : station requests and vend parameters
//   gnt, done                       : per-station grant and completion pulse
//   disp_A, disp_B, change, busy    : mechanism drives and activity flag
// master = vend stations, slave = scheduler.
interface vend_dispense_sched_if #(
    parameter int CHG_W = vend_pkg::CHG_W_DEF
);
    logic [1:0]       req;
    logic [1:0]       item_b;
    logic [CHG_W-1:0] chg_cnt0;
    logic [CHG_W-1:0] chg_cnt1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic             disp_A;
    logic             disp_B;
    logic             change;
    logic             busy;

    modport master (
        output req, item_b, chg_cnt0, chg_cnt1,
        input  gnt, done, disp_A, disp_B, change, busy
    );

    modport slave (
        input  req, item_b, chg_cnt0, chg_cnt1,
        output gnt, done, disp_A, disp_B, change, busy
    );
endinterface

// File: rtl/vend_dispense_sched_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin picker.
//   req[1:0]  : requests
//   last      : station served most recently
//   pick[1:0] : one-hot winner (zero when nothing requests)
//   any       : at least one request present
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick,
    output logic       any
);
    always_comb begin
        pick = '0;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            // Contention goes to the station not served last.
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = '0;
        endcase
        any = |req;
    end
endmodule

// File: rtl/vend_dispense_sched.sv
// vend_dispense_sched: grants the shared dispenser/hopper to one of two
// stations, runs the motor pulse and change-coin pulses, then pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : station bus (slave side), see vend_dispense_sched_if
// All outputs are registered: they are computed from the next state.
module vend_dispense_sched
    import vend_pkg::*;
#(
    parameter int DISP_CYC = 2,
    parameter int CHG_W    = CHG_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    vend_dispense_sched_if.slave  bus
);
    localparam logic [3:0] DCNT_INIT = 4'(DISP_CYC - 1);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             itm_q, itm_d;
    logic [CHG_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             last_q, last_d;

    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic       disp_a_q, disp_a_d;
    logic       disp_b_q, disp_b_d;
    logic       change_q, change_d;
    logic       busy_q, busy_d;

    logic [1:0] pick;
    logic       any;
    logic [1:0] sel_oh;

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        itm_d   = itm_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (any) begin
                    sel_d   = pick[1];
                    itm_d   = bus.item_b[pick[1]];
                    cnt_d   = pick[1] ? bus.chg_cnt1 : bus.chg_cnt0;
                    dcnt_d  = DCNT_INIT;
                    state_d = DISP;
                end
            end
            DISP: begin
                if (dcnt_q != '0) begin
                    dcnt_d = dcnt_q - 4'd1;
                end else begin
                    state_d = (cnt_q == '0) ? DONE : CHG_ON;
                end
            end
            CHG_ON: begin
                cnt_d   = cnt_q - CHG_W'(1);
                state_d = CHG_OFF;
            end
            CHG_OFF: begin
                state_d = (cnt_q == '0) ? DONE : CHG_ON;
            end
            DONE: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs decode the state being entered so they appear registered.
        sel_oh   = sel_d ? 2'b10 : 2'b01;
        busy_d   = (state_d != IDLE);
        gnt_d    = busy_d ? sel_oh : '0;
        done_d   = (state_d == DONE) ? sel_oh : '0;
        disp_a_d = (state_d == DISP) && (itm_d == ITEM_A);
        disp_b_d = (state_d == DISP) && (itm_d == ITEM_B);
        change_d = (state_d == CHG_ON);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            itm_q    <= 1'b0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            last_q   <= 1'b1;
            gnt_q    <= '0;
            done_q   <= '0;
            disp_a_q <= 1'b0;
            disp_b_q <= 1'b0;
            change_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            itm_q    <= itm_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            disp_a_q <= disp_a_d;
            disp_b_q <= disp_b_d;
            change_q <= change_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.disp_A = disp_a_q;
    assign bus.disp_B = disp_b_q;
    assign bus.change = change_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_vend_dispense_sched.sv
// tb_vend_dispense_sched: directed and randomized checks of the dispense
// scheduler against a timeline model (offsets from the grant cycle).
module tb_vend_dispense_sched;
    localparam int D = 2;
    localparam int W = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vend_dispense_sched_if #(.CHG_W(W)) bus ();

    vend_dispense_sched #(.DISP_CYC(D), .CHG_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one service described by station, item, coins and
    // the cycle offset t since the grant.
    logic m_active = 1'b0;
    int   m_st     = 0;
    logic m_item   = 1'b0;
    int   m_n      = 0;
    int   m_t      = 0;
    int   m_last   = 1;

    logic [1:0] cont       = 2'b00;
    logic [1:0] rearm      = 2'b00;
    logic [1:0] just_done  = 2'b00;
    int         gq[$];
    int         nchg;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [1:0] oh;
        int         end_t;
        logic       mot;
        logic       chg;
        if (!m_active) return 8'h00;
        oh    = (m_st == 1) ? 2'b10 : 2'b01;
        end_t = D + 2 * m_n;
        mot   = (m_t < D);
        chg   = (m_t >= D) && (m_t < end_t) && (((m_t - D) % 2) == 0);
        return {oh, (m_t == end_t) ? oh : 2'b00, mot && !m_item, mot && m_item, chg, 1'b1};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_active = 1'b0;
            m_last   = 1;
        end else if (m_active) begin
            m_t++;
            if (m_t > D + 2 * m_n) begin
                m_active = 1'b0;
                m_last   = m_st;
            end
        end else if (bus.req != 2'b00) begin
            if (bus.req == 2'b11) m_st = (m_last == 1) ? 0 : 1;
            else                  m_st = bus.req[1] ? 1 : 0;
            m_item   = bus.item_b[m_st];
            m_n      = (m_st == 1) ? int'(bus.chg_cnt1) : int'(bus.chg_cnt0);
            m_t      = 0;
            m_active = 1'b1;
        end
    endtask

    task automatic step(string tag);
        logic [7:0] e;
        @(posedge clk);
        model_edge();
        #1;
        e = exp_vec();
        check(tag, {24'b0, bus.gnt, bus.done, bus.disp_A, bus.disp_B, bus.change, bus.busy},
              {24'b0, e});
        if (m_active && m_t == 0) gq.push_back(m_st);
        for (int i = 0; i < 2; i++) begin
            just_done[i] = e[4+i];
            if (e[4+i]) begin
                bus.req[i] = 1'b0;
                if (cont[i]) rearm[i] = 1'b1;
            end else if (rearm[i]) begin
                bus.req[i] = 1'b1;
                rearm[i]   = 1'b0;
            end
        end
    endtask

    task automatic drain(string tag);
        for (int k = 0; k < 60; k++) begin
            if (!m_active && bus.req == 2'b00) break;
            step(tag);
        end
        check({tag, "_idle"}, {31'b0, m_active || (bus.req != 2'b00)}, 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.req      = 2'b11;
        bus.item_b   = 2'b00;
        bus.chg_cnt0 = '0;
        bus.chg_cnt1 = '0;

        // Reset held with both stations requesting.
        repeat (3) step("rst_hold");
        check("rst_gnt", 32'(bus.gnt), 32'h0);

        // Station 0, item A, no change.
        bus.req = 2'b01;
        rst     = 1'b0;
        step("a0_c0");
        check("a0_gnt_c0", 32'(bus.gnt), 32'h1);
        check("a0_dispA_c0", 32'(bus.disp_A), 32'h1);
        step("a0_c1");
        step("a0_c2");
        check("a0_done_c2", 32'(bus.done), 32'h1);
        step("a0_idle");
        check("a0_busy_idle", 32'(bus.busy), 32'h0);

        // Station 1, item B, three coins.
        bus.item_b   = 2'b10;
        bus.chg_cnt1 = 2'd3;
        bus.req      = 2'b10;
        nchg         = 0;
        for (int c = 0; c < 9; c++) begin
            step("b1_svc");
            if (bus.change) nchg++;
        end
        check("b1_coins", 32'(nchg), 32'd3);
        check("b1_done_c8", 32'(bus.done), 32'h2);
        step("b1_idle");

        // Fairness with continuous re-requests.
        rst = 1'b1;
        step("rst2");
        rst          = 1'b0;
        bus.chg_cnt0 = 2'd1;
        bus.chg_cnt1 = 2'd2;
        bus.req      = 2'b11;
        cont         = 2'b11;
        gq.delete();
        for (int k = 0; k < 80; k++) begin
            if (gq.size() >= 4) break;
            step("fair");
        end
        check("fair_count", 32'(gq.size() >= 4), 32'h1);
        for (int k = 0; k < 4; k++)
            if (k < gq.size()) check("fair_order", 32'(gq[k]), 32'(k % 2));
        cont  = 2'b00;
        rearm = 2'b00;
        drain("fair_drain");

        // Reset in cycle 3 of a two-coin vend.
        bus.item_b   = 2'b00;
        bus.chg_cnt0 = 2'd2;
        bus.req      = 2'b01;
        for (int c = 0; c < 4; c++) step("mrst_svc");
        rst = 1'b1;
        step("mrst_rst");
        check("mrst_zero", {24'b0, bus.gnt, bus.done, bus.disp_A, bus.disp_B, bus.change, bus.busy}, 32'h0);
        rst     = 1'b0;
        bus.req = 2'b11;
        step("mrst_regrant");
        check("mrst_gnt0", 32'(bus.gnt), 32'h1);
        drain("mrst_drain");

        // Station 0 drops req in cycle 1 of a one-coin vend.
        bus.item_b   = 2'b01;
        bus.chg_cnt0 = 2'd1;
        bus.req      = 2'b01;
        step("drop_c0");
        step("drop_c1");
        bus.req[0] = 1'b0;
        step("drop_c2");
        check("drop_chg_c2", 32'(bus.change), 32'h1);
        step("drop_c3");
        step("drop_c4");
        check("drop_done_c4", 32'(bus.done), 32'h1);
        step("drop_idle");

        // Randomized traffic; item/count inputs churn every cycle.
        for (int k = 0; k < 500; k++) begin
            step("rand");
            bus.item_b   = 2'($urandom);
            bus.chg_cnt0 = W'($urandom);
            bus.chg_cnt1 = W'($urandom);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 79) == 0) rst = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (!bus.req[i] && !just_done[i] && $urandom_range(0, 3) == 0)
                    bus.req[i] = 1'b1;
            end
            if (m_active && bus.req[m_st] && $urandom_range(0, 24) == 0)
                bus.req[m_st] = 1'b0;
        end
        rst = 1'b0;
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
